restoring_divider_param: RTL

Parametrised sequential restoring divider. Successor to the fixed 8-bit divider used in the datapath. Generalised to WIDTH bits, with an optional signed mode, a divide-by-zero flag, a signed-overflow flag and a one-cycle done pulse. Sits beside the ALU as a multi-cycle unit started by a strobe and polled via ready.

---
 rtl/divider_pkg.sv | 18 +
 rtl/div_step.sv | 28 ++
 rtl/restoring_divider_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the parametrised restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH+1:0] w_a_sh;
    logic [WIDTH+1:0] w_trial;

    // Shifted A keeps every bit of A; the extra top bit of the trial is the borrow.
    always_comb begin
        w_a_sh  = {a_in, q_in[WIDTH-1]};
        w_trial = w_a_sh - {2'b00, m_in};
        if (w_trial[WIDTH+1] == 1'b0) begin
            a_out = w_trial[WIDTH:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            a_out = w_a_sh[WIDTH:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle restoring divider with optional two's-complement mode, started by a strobe and polled via ready.
module restoring_divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] Qbus_in,
    input  logic [WIDTH-1:0] Mbus_in,
    output logic [WIDTH-1:0] Abus_out,
    output logic [WIDTH-1:0] Qbus_out,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_VAL) : v;
    endfunction

    state_e           r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_p;
    logic             r_ovf_p;
    logic [WIDTH-1:0] r_abus;
    logic [WIDTH-1:0] r_qbus;
    logic             r_ready;
    logic             r_done;
    logic             r_dz;
    logic             r_ovf;

    logic             w_sgn;
    logic             w_d_neg;
    logic             w_m_neg;
    logic             w_is_ovf;
    logic [WIDTH:0]   w_a_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_a_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (r_a),
        .q_in  (r_q),
        .m_in  (r_m),
        .a_out (w_a_nx),
        .q_out (w_q_nx)
    );

    // Operand sign decode at start, and sign correction of the magnitude result.
    always_comb begin
        if (SIGNED_EN) begin
            w_sgn = signed_mode;
        end else begin
            w_sgn = 1'b0;
        end
        w_d_neg  = w_sgn & Qbus_in[WIDTH-1];
        w_m_neg  = w_sgn & Mbus_in[WIDTH-1];
        w_is_ovf = w_sgn && (Qbus_in == MIN_VAL) && (Mbus_in == {WIDTH{1'b1}});
        w_q_fix  = mag(r_q, r_neg_q);
        w_a_fix  = mag(r_a[WIDTH-1:0], r_neg_r);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz_p  <= 1'b0;
            r_ovf_p <= 1'b0;
            r_abus  <= '0;
            r_qbus  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (st) begin
                        r_ready <= 1'b0;
                        r_dz    <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_ovf_p <= w_is_ovf;
                        r_m     <= mag(Mbus_in, w_m_neg);
                        if (Mbus_in == {WIDTH{1'b0}}) begin
                            // Zero divisor: skip iterations, report all-ones quotient and dividend as remainder.
                            r_a     <= {1'b0, Qbus_in};
                            r_q     <= {WIDTH{1'b1}};
                            r_cnt   <= '0;
                            r_dz_p  <= 1'b1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= ST_FIX;
                        end else begin
                            r_a     <= '0;
                            r_q     <= mag(Qbus_in, w_d_neg);
                            r_cnt   <= CNT_W'(WIDTH);
                            r_dz_p  <= 1'b0;
                            r_neg_q <= w_d_neg ^ w_m_neg;
                            r_neg_r <= w_d_neg;
                            r_state <= ST_ITER;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    r_a   <= w_a_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_ITER;
                    end
                end
                ST_FIX: begin
                    r_qbus  <= w_q_fix;
                    r_abus  <= w_a_fix;
                    r_dz    <= r_dz_p;
                    r_ovf   <= r_ovf_p;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Abus_out    = r_abus;
    assign Qbus_out    = r_qbus;
    assign ready       = r_ready;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign overflow    = SIGNED_EN ? r_ovf : 1'b0;

endmodule
